decode_stage_fwd: RTL

Parametrised successor decode stage for the 5-stage MIPS pipeline. It holds a ready/valid pipeline register and an NREG x W register file with write-through. It forwards operands from EX, MEM and WB, detects load-use hazards and inserts bubbles. It resolves branches and jumps in decode and issues a redirect to fetch. It sits between fetch and execute.

---
 rtl/decode_fwd_pkg.sv | 35 +++
 rtl/fwd_regfile.sv | 33 +++
 rtl/decode_stage_fwd.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/decode_fwd_pkg.sv
// Shared decode-stage definitions: control-bundle bit positions, dest_sel
// encodings and MIPS instruction field slices.
package decode_fwd_pkg;

  // Control bundle layout; everything at or above CF_DECODE_W passes through.
  localparam int CF_ALU_FUNC     = 0;   // [5:0]
  localparam int CF_DEST_SEL     = 6;   // [7:6]
  localparam int CF_ALU_A_SEL    = 8;
  localparam int CF_ALU_B_SEL    = 9;
  localparam int CF_IMM_UNSIGNED = 10;
  localparam int CF_LUI          = 11;
  localparam int CF_REG_WRITE    = 12;
  localparam int CF_USES_RS      = 13;
  localparam int CF_USES_RT      = 14;
  localparam int CF_IS_BRANCH    = 15;
  localparam int CF_BRANCH_NE    = 16;
  localparam int CF_IS_JUMP      = 17;
  localparam int CF_JUMP_REG     = 18;
  localparam int CF_DECODE_W     = 19;

  typedef enum logic [1:0] {
    DEST_RT   = 2'd0,
    DEST_RD   = 2'd1,
    DEST_RA   = 2'd2,
    DEST_NONE = 2'd3
  } dest_sel_e;

  function automatic logic [4:0]  instr_rs(input logic [31:0] i);    return i[25:21]; endfunction
  function automatic logic [4:0]  instr_rt(input logic [31:0] i);    return i[20:16]; endfunction
  function automatic logic [4:0]  instr_rd(input logic [31:0] i);    return i[15:11]; endfunction
  function automatic logic [4:0]  instr_shamt(input logic [31:0] i); return i[10:6];  endfunction
  function automatic logic [15:0] instr_imm(input logic [31:0] i);   return i[15:0];  endfunction
  function automatic logic [25:0] instr_jidx(input logic [31:0] i);  return i[25:0];  endfunction

endpackage

// File: rtl/fwd_regfile.sv
// NREG x W register file, async clear, combinational reads with a
// same-cycle writeback bypass. Entry 0 is never written so it reads 0.
module fwd_regfile #(
  parameter int W    = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRP  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_en,
  input  logic [AW-1:0]            wb_dest,
  input  logic [W-1:0]             wb_data,
  input  logic [NRP-1:0][AW-1:0]   rd_idx,
  output logic [NRP-1:0][W-1:0]    rd_data
);

  logic [W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wb_en && wb_dest != '0) begin
      mem[wb_dest] <= wb_data;
    end
  end

  for (genvar g = 0; g < NRP; g++) begin : g_rd
    assign rd_data[g] = (wb_en && wb_dest == rd_idx[g] && rd_idx[g] != '0) ? wb_data
                                                                           : mem[rd_idx[g]];
  end

endmodule

// File: rtl/decode_stage_fwd.sv
// MIPS decode stage: ready/valid D register, operand forwarding (EX > MEM > WB
// > regfile), load-use bubble insertion and in-decode branch/jump redirect.
module decode_stage_fwd
  import decode_fwd_pkg::*;
#(
  parameter int W      = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int CTRL_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [W-1:0]      in_pc_seq,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [AW-1:0]     ex_dest,
  input  logic [W-1:0]      ex_data,
  input  logic              mem_valid,
  input  logic [AW-1:0]     mem_dest,
  input  logic [W-1:0]      mem_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_dest,
  input  logic [W-1:0]      wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [W-1:0]      out_operand_a,
  output logic [W-1:0]      out_operand_b,
  output logic [W-1:0]      out_reg_read2,
  output logic [AW-1:0]     out_dest,
  output logic              out_reg_write_en,
  output logic [W-1:0]      out_pc_seq,
  output logic              redirect_valid,
  output logic [W-1:0]      redirect_pc
);

  logic              d_valid;
  logic [31:0]       d_instr;
  logic [W-1:0]      d_pc_seq;
  logic [CTRL_W-1:0] d_ctrl;
  logic              hazard;

  assign in_ready  = !d_valid || (out_ready && !hazard);
  assign out_valid = d_valid && !hazard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid  <= 1'b0;
      d_instr  <= '0;
      d_pc_seq <= '0;
      d_ctrl   <= '0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      d_valid  <= 1'b1;
      d_instr  <= in_instr;
      d_pc_seq <= in_pc_seq;
      d_ctrl   <= in_ctrl;
    end else if (out_valid && out_ready) begin
      d_valid <= 1'b0;
    end
  end

  // Opcode bits are consumed by the control unit upstream, not here.
  logic unused_opcode;
  assign unused_opcode = ^d_instr[31:26];

  logic [AW-1:0] rs, rt, rd;
  assign rs = AW'(instr_rs(d_instr));
  assign rt = AW'(instr_rt(d_instr));
  assign rd = AW'(instr_rd(d_instr));

  // Source port 0 = rs, 1 = rt.
  logic [1:0][AW-1:0] src_idx;
  logic [1:0][W-1:0]  src_rf, src_val;
  assign src_idx = {rt, rs};

  fwd_regfile #(.W(W), .NREG(NREG), .AW(AW), .NRP(2)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_dest (wb_dest),
    .wb_data (wb_data),
    .rd_idx  (src_idx),
    .rd_data (src_rf)
  );

  // Loads in EX have no data yet; they are handled by the hazard stall instead.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    assign src_val[g] =
        (src_idx[g] == '0)                                      ? src_rf[g] :
        (ex_valid && !ex_is_load && ex_dest == src_idx[g])      ? ex_data   :
        (mem_valid && mem_dest == src_idx[g])                   ? mem_data  :
                                                                  src_rf[g];
  end

  logic [W-1:0] fwd_rs, fwd_rt;
  assign fwd_rs = src_val[0];
  assign fwd_rt = src_val[1];

  assign hazard = d_valid && ex_valid && ex_is_load && (ex_dest != '0) &&
                  ((d_ctrl[CF_USES_RS] && rs == ex_dest) ||
                   (d_ctrl[CF_USES_RT] && rt == ex_dest));

  logic [15:0]  imm16;
  logic [W-1:0] imm_ext, imm_sext;
  assign imm16    = instr_imm(d_instr);
  assign imm_sext = W'($signed(imm16));
  assign imm_ext  = d_ctrl[CF_LUI]          ? W'({imm16, 16'h0000}) :
                    d_ctrl[CF_IMM_UNSIGNED] ? W'(imm16)             :
                                              imm_sext;

  assign out_operand_a = d_ctrl[CF_ALU_A_SEL] ? W'(instr_shamt(d_instr)) : fwd_rs;
  assign out_operand_b = d_ctrl[CF_ALU_B_SEL] ? imm_ext : fwd_rt;
  assign out_reg_read2 = fwd_rt;
  assign out_ctrl      = d_ctrl;
  assign out_pc_seq    = d_pc_seq;

  always_comb begin
    case (d_ctrl[CF_DEST_SEL +: 2])
      DEST_RT: out_dest = rt;
      DEST_RD: out_dest = rd;
      DEST_RA: out_dest = AW'(5'd31);
      default: out_dest = '0;
    endcase
  end

  assign out_reg_write_en = d_ctrl[CF_REG_WRITE] && (out_dest != '0);

  logic         fire_ok, br_eq, br_taken;
  logic [W-1:0] br_target, j_target;
  assign fire_ok   = out_valid && out_ready && !flush;
  assign br_eq     = (fwd_rs == fwd_rt);
  assign br_taken  = d_ctrl[CF_IS_BRANCH] && (d_ctrl[CF_BRANCH_NE] ? !br_eq : br_eq);
  assign br_target = d_pc_seq + (imm_sext << 2);
  assign j_target  = {d_pc_seq[W-1:28], instr_jidx(d_instr), 2'b00};

  assign redirect_valid = fire_ok && (br_taken || d_ctrl[CF_IS_JUMP]);
  assign redirect_pc    = d_ctrl[CF_IS_JUMP] ? (d_ctrl[CF_JUMP_REG] ? fwd_rs : j_target)
                                             : br_target;

endmodule
